// File: rtl/cpu_datapath.sv
// cpu_datapath: register/ALU datapath of the 8-bit CPU (state, PC, IR, A, B, alu_q, zf, MDR, halted).
// Optional build macro JUMP_SIGNED_EN: sign-extend pc_offset for backward jumps (default: zero-extend).
`default_nettype none

module cpu_datapath #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        next_state,
  input  logic              pc_we,
  input  logic              pc_sel,
  input  logic [3:0]        pc_offset,
  input  logic              addr_sel,
  input  logic [3:0]        addr_offset,
  input  logic              mem_sel,
  input  logic              mem_we_in,
  input  logic [2:0]        alu_opcode,
  input  logic              alu_sel_a,
  input  logic              alu_sel_b,
  input  logic              alu_we,
  input  logic              zf_we,
  input  logic              ir_we,
  input  logic              a_sel,
  input  logic              b_sel,
  input  logic              a_we,
  input  logic              b_we,
  input  logic              halt,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [7:0]        instr,
  output logic [7:0]        state,
  output logic              zf,
  output logic              halted
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;

  logic [7:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [7:0]        alu_q, alu_d;
  logic              zf_q, zf_d;
  logic [7:0]        mdr_q;
  logic              halted_q;

  logic [ADDR_W-1:0] jump_ext;
  logic [ADDR_W-1:0] addr_ext;
  logic [7:0]        alu_x, alu_y, alu_res;

`ifdef JUMP_SIGNED_EN
  assign jump_ext = {{(ADDR_W-4){pc_offset[3]}}, pc_offset};
`else
  assign jump_ext = {{(ADDR_W-4){1'b0}}, pc_offset};
`endif
  assign addr_ext = {{(ADDR_W-4){1'b0}}, addr_offset};

  always_comb begin
    alu_x = alu_sel_a ? b_q : a_q;
    alu_y = alu_sel_b ? b_q : a_q;
    case (alu_opcode)
      ALU_ADD: alu_res = alu_x + alu_y;
      ALU_AND: alu_res = alu_x & alu_y;
      ALU_NOT: alu_res = ~alu_x;
      default: alu_res = 8'h00;
    endcase
  end

  // Next-state values; the halt freeze is applied in the register process.
  always_comb begin
    state_d = next_state;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    zf_d    = zf_q;
    if (pc_we) begin
      pc_d = pc_sel ? (pc_q + jump_ext) : (pc_q + ADDR_W'(1));
    end
    if (ir_we)  ir_d  = mem_rdata;
    if (a_we)   a_d   = a_sel ? alu_q : mdr_q;
    if (b_we)   b_d   = b_sel ? alu_q : mdr_q;
    if (alu_we) alu_d = alu_res;
    if (zf_we)  zf_d  = (alu_res == 8'h00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= 8'h00;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      alu_q    <= 8'h00;
      zf_q     <= 1'b0;
      mdr_q    <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      mdr_q <= mem_rdata;
      if (halt) halted_q <= 1'b1;
      if (!halted_q) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        ir_q    <= ir_d;
        a_q     <= a_d;
        b_q     <= b_d;
        alu_q   <= alu_d;
        zf_q    <= zf_d;
      end
    end
  end

  assign mem_addr  = addr_sel ? (pc_q + addr_ext) : pc_q;
  assign mem_wdata = mem_sel ? b_q : a_q;
  assign mem_we    = mem_we_in & ~halted_q;
  assign instr     = ir_q;
  assign state     = state_q;
  assign zf        = zf_q;
  assign halted    = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed scoreboard bench for cpu_datapath.
`default_nettype none

module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] next_state;
  logic       pc_we, pc_sel, addr_sel, mem_sel, mem_we_in;
  logic [3:0] pc_offset, addr_offset;
  logic [2:0] alu_opcode;
  logic       alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we;
  logic       a_sel, b_sel, a_we, b_we, halt;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr, mem_wdata, instr, state;
  logic       mem_we, zf, halted;

  cpu_datapath #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .next_state(next_state),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_offset(pc_offset),
    .addr_sel(addr_sel), .addr_offset(addr_offset), .mem_sel(mem_sel),
    .mem_we_in(mem_we_in), .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a),
    .alu_sel_b(alu_sel_b), .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we),
    .a_sel(a_sel), .b_sel(b_sel), .a_we(a_we), .b_we(b_we), .halt(halt),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .instr(instr), .state(state), .zf(zf), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_pc  = 8'h00;

  task automatic push(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pc_we = 0; pc_sel = 0; pc_offset = 0; addr_sel = 0; addr_offset = 0;
    mem_sel = 0; mem_we_in = 0; alu_opcode = 0; alu_sel_a = 0; alu_sel_b = 0;
    alu_we = 0; zf_we = 0; ir_we = 0; a_sel = 0; b_sel = 0; a_we = 0; b_we = 0;
    halt = 0;
  endtask

  // A and B are observed through mem_wdata by flipping mem_sel.
  task automatic check_a(input string tag, input logic [7:0] exp);
    mem_sel = 0; #0.1;
    push(tag, exp); pop_cmp(mem_wdata);
  endtask

  task automatic check_b(input string tag, input logic [7:0] exp);
    mem_sel = 1; #0.1;
    push(tag, exp); pop_cmp(mem_wdata);
    mem_sel = 0;
  endtask

  task automatic check_pc(input string tag);
    addr_sel = 0; #0.1;
    push(tag, m_pc); pop_cmp(mem_addr);
  endtask

  task automatic pc_inc_to(input logic [7:0] target);
    pc_we = 1; pc_sel = 0;
    while (m_pc != target) begin
      step();
      m_pc = m_pc + 8'h01;
    end
    pc_we = 0;
  endtask

  initial begin
    logic [7:0] jump_exp;
    reset_n = 0; next_state = 8'h00; mem_rdata = 8'h00;
    clr();
    #12;
    check_pc("rst_pc");
    check_a("rst_a", 8'h00);
    check_b("rst_b", 8'h00);
    push("rst_instr", 8'h00);  pop_cmp(instr);
    push("rst_state", 8'h00);  pop_cmp(state);
    push("rst_zf", 8'h00);     pop_cmp({7'b0, zf});
    push("rst_halted", 8'h00); pop_cmp({7'b0, halted});
    #1 reset_n = 1;

    // State follows next_state; fetch loads IR from old PC while PC increments
    next_state = 8'h01;
    step();
    push("state_follow", 8'h01); pop_cmp(state);
    mem_rdata = 8'hA5; ir_we = 1; pc_we = 1;
    step();
    m_pc = 8'h01;
    ir_we = 0; pc_we = 0;
    push("fetch_ir", 8'hA5); pop_cmp(instr);
    check_pc("fetch_pc");

    // Load A=0x7F, B=0x81 through MDR, then ADD -> 0x00 sets zf
    mem_rdata = 8'h7F; step();
    a_we = 1; step(); a_we = 0;
    check_a("load_a", 8'h7F);
    mem_rdata = 8'h81; step();
    b_we = 1; step(); b_we = 0;
    check_b("load_b", 8'h81);
    alu_opcode = 3'b000; alu_sel_a = 0; alu_sel_b = 1; alu_we = 1; zf_we = 1;
    step();
    alu_we = 0; zf_we = 0;
    push("add_zf", 8'h01); pop_cmp({7'b0, zf});
    a_sel = 1; a_we = 1; step(); a_we = 0;
    check_a("add_result", 8'h00);

    // NOT B -> 0x7E clears zf; copy into B
    alu_opcode = 3'b010; alu_sel_a = 1; alu_we = 1; zf_we = 1;
    step();
    alu_we = 0; zf_we = 0;
    push("not_zf", 8'h00); pop_cmp({7'b0, zf});
    b_sel = 1; b_we = 1; step(); b_we = 0;
    check_b("not_result", 8'h7E);

    // Same-edge write and read of alu_q: A takes the old alu_q
    alu_opcode = 3'b000; alu_sel_a = 1; alu_sel_b = 1; alu_we = 1;
    a_sel = 1; a_we = 1;
    step();
    alu_we = 0; a_we = 0;
    check_a("old_alu_q", 8'h7E);
    a_we = 1; step(); a_we = 0;
    check_a("add_bb", 8'hFC);

    // AND of A and B: 0xFC & 0x7E = 0x7C
    alu_opcode = 3'b001; alu_sel_a = 0; alu_sel_b = 1; alu_we = 1; zf_we = 1;
    step();
    alu_we = 0; zf_we = 0;
    a_we = 1; step(); a_we = 0;
    check_a("and_result", 8'h7C);

    // Undefined opcode yields zero
    alu_opcode = 3'b111; zf_we = 1; step(); zf_we = 0;
    push("undef_op_zf", 8'h01); pop_cmp({7'b0, zf});

    // PC wrap and address offset wrap
    pc_inc_to(8'hFF);
    check_pc("pc_ff");
    pc_we = 1; step(); pc_we = 0; m_pc = 8'h00;
    check_pc("pc_wrap");
    pc_inc_to(8'hFE);
    addr_sel = 1; addr_offset = 4'd4; #0.1;
    push("addr_wrap", 8'h02); pop_cmp(mem_addr);
    addr_sel = 0; addr_offset = 0;

    // Jump with offset 0xE
    pc_inc_to(8'h10);
`ifdef JUMP_SIGNED_EN
    jump_exp = 8'h0E;
`else
    jump_exp = 8'h1E;
`endif
    pc_we = 1; pc_sel = 1; pc_offset = 4'hE;
    step();
    pc_we = 0; pc_sel = 0; pc_offset = 0;
    m_pc = jump_exp;
    check_pc("jump");

    // Store B to PC+3
    pc_inc_to(8'h20);
    mem_rdata = 8'h5A; step();
    b_sel = 0; b_we = 1; step(); b_we = 0;
    addr_sel = 1; addr_offset = 4'd3; mem_sel = 1; mem_we_in = 1; #0.1;
    push("store_addr", 8'h23);  pop_cmp(mem_addr);
    push("store_wdata", 8'h5A); pop_cmp(mem_wdata);
    push("store_we", 8'h01);    pop_cmp({7'b0, mem_we});
    clr();

    // Asynchronous reset in the middle of a cycle
    next_state = 8'h07; step();
    #3 reset_n = 0;
    m_pc = 8'h00;
    #0.5;
    check_pc("mid_rst_pc");
    check_a("mid_rst_a", 8'h00);
    check_b("mid_rst_b", 8'h00);
    push("mid_rst_state", 8'h00); pop_cmp(state);
    push("mid_rst_instr", 8'h00); pop_cmp(instr);
    push("mid_rst_zf", 8'h00);    pop_cmp({7'b0, zf});
    #1 reset_n = 1;
    next_state = 8'h00;

    // Halt freezes architectural state and blocks memory writes
    mem_rdata = 8'h33; step();
    a_we = 1; step(); a_we = 0;
    next_state = 8'h05; step();
    push("pre_halt_state", 8'h05); pop_cmp(state);
    mem_rdata = 8'h44; halt = 1; next_state = 8'h06;
    step();
    halt = 0;
    push("halted_set", 8'h01); pop_cmp({7'b0, halted});
    next_state = 8'h09; pc_we = 1; a_we = 1; mem_we_in = 1; #0.1;
    push("halt_mem_we", 8'h00); pop_cmp({7'b0, mem_we});
    step();
    step();
    pc_we = 0; a_we = 0; mem_we_in = 0;
    push("halt_state", 8'h06); pop_cmp(state);
    check_pc("halt_pc");
    check_a("halt_a", 8'h33);
    push("halted_sticky", 8'h01); pop_cmp({7'b0, halted});

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
